// File: rtl/di_stream_fifo_term.sv
// Device-interface terminal: buffers a producer's 16-bit stream in a FWFT FIFO for host
// read bursts, and exposes CTRL/COUNT/OVERFLOW/UNDERFLOW/DEPTH registers.
module di_stream_fifo_term #(
  parameter logic [15:0] TERM_ADDR  = 16'h0010,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic [15:0] di_term_addr,
  input  logic [15:0] di_reg_addr,
  input  logic [15:0] di_reg_datai,
  output logic [15:0] di_reg_datao,
  input  logic        di_read,
  output logic        di_read_rdy,
  input  logic        di_write,
  output logic        di_write_rdy,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PtrOne = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [15:0] mem [Depth];

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  enable_q, enable_d;
  logic [15:0]           overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full_q, empty_q;

  logic sel, data_win, reg_wr, flush, nonempty, has_room, pop, push, drop, under;
  logic unused_datai;

  assign sel      = (di_term_addr == TERM_ADDR);
  assign data_win = di_reg_addr[15];
  assign reg_wr   = sel & ~data_win & di_write;
  assign flush    = reg_wr & (di_reg_addr == 16'd0) & di_reg_datai[1];
  assign nonempty = (count_q != '0);
  assign has_room = (count_q < DepthCnt);
  // Room is judged on the pre-pop count, so a full FIFO drops even when popped.
  assign pop      = sel & data_win & di_read & nonempty & ~flush;
  assign under    = sel & data_win & di_read & ~nonempty;
  assign push     = wr_en & enable_q & has_room & ~flush;
  assign drop     = wr_en & enable_q & ~has_room & ~flush;

  assign unused_datai = ^di_reg_datai[15:2];

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    enable_d    = enable_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrOne;
      if (pop)  rptr_d = rptr_q + PtrOne;
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end
    if (reg_wr && di_reg_addr == 16'd0) enable_d = di_reg_datai[0];
    // A clearing write beats a same-cycle increment.
    if (reg_wr && di_reg_addr == 16'd2) begin
      overflow_d = '0;
    end else if (drop && overflow_q != 16'hFFFF) begin
      overflow_d = overflow_q + 16'd1;
    end
    if (reg_wr && di_reg_addr == 16'd3) begin
      underflow_d = '0;
    end else if (under && underflow_q != 16'hFFFF) begin
      underflow_d = underflow_q + 16'd1;
    end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
      overflow_q  <= '0;
      underflow_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      full_q      <= (count_d == DepthCnt);
      empty_q     <= (count_d == '0);
    end
  end

  always_ff @(posedge ifclk) begin
    if (push) mem[wptr_q] <= wr_data;
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;

  always_comb begin
    di_reg_datao = '0;
    di_read_rdy  = 1'b0;
    di_write_rdy = 1'b0;
    if (sel) begin
      di_write_rdy = 1'b1;
      if (data_win) begin
        // Comparing against di_read keeps the host's registered rdy right at one word left.
        di_read_rdy = (count_q > {{DEPTH_LOG2{1'b0}}, di_read});
        if (nonempty) di_reg_datao = mem[rptr_q];
      end else begin
        di_read_rdy = 1'b1;
        case (di_reg_addr)
          16'd0:   di_reg_datao = {15'd0, enable_q};
          16'd1:   di_reg_datao = 16'(count_q);
          16'd2:   di_reg_datao = overflow_q;
          16'd3:   di_reg_datao = underflow_q;
          16'd4:   di_reg_datao = 16'(DepthCnt);
          default: di_reg_datao = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_di_stream_fifo_term.sv
// Bench for di_stream_fifo_term: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_di_stream_fifo_term;
  localparam logic [15:0] TermAddr = 16'h0010;
  localparam int Depth = 512;

  logic        ifclk = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] di_term_addr = '0, di_reg_addr = '0, di_reg_datai = '0, wr_data = '0;
  logic        di_read = 1'b0, di_write = 1'b0, wr_en = 1'b0;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy, fifo_full, fifo_empty;

  always #5 ifclk = ~ifclk;

  di_stream_fifo_term #(.TERM_ADDR(TermAddr), .DEPTH_LOG2(9)) dut (
    .ifclk(ifclk), .resetb(resetb), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_reg_datai(di_reg_datai), .di_reg_datao(di_reg_datao), .di_read(di_read),
    .di_read_rdy(di_read_rdy), .di_write(di_write), .di_write_rdy(di_write_rdy),
    .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] q[$];
  logic        m_en = 1'b0;
  int          m_ovf = 0, m_unf = 0;

  typedef struct {
    logic [15:0] term, addr, datai;
    logic        rd, wr, we;
    logic [15:0] wd, e_do;
    logic        e_rr, e_wr;
  } vec_t;

  function automatic vec_t v(logic [15:0] term, addr, datai, logic rd, wr, we,
                             logic [15:0] wd, e_do, logic e_rr, e_wr);
    vec_t r;
    r = '{term, addr, datai, rd, wr, we, wd, e_do, e_rr, e_wr};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] reg_val(input logic [15:0] a);
    case (a)
      16'd0:   return {15'd0, m_en};
      16'd1:   return 16'(q.size());
      16'd2:   return 16'(m_ovf);
      16'd3:   return 16'(m_unf);
      16'd4:   return 16'(Depth);
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_check();
    logic [15:0] e_do;
    logic        e_rr, e_wr;
    e_do = '0; e_rr = 1'b0; e_wr = 1'b0;
    if (di_term_addr == TermAddr) begin
      e_wr = 1'b1;
      if (di_reg_addr[15]) begin
        e_rr = q.size() > int'(di_read);
        if (q.size() > 0) e_do = q[0];
      end else begin
        e_rr = 1'b1;
        e_do = reg_val(di_reg_addr);
      end
    end
    chk("model_datao", di_reg_datao, e_do);
    chk("model_read_rdy", di_read_rdy, e_rr);
    chk("model_write_rdy", di_write_rdy, e_wr);
  endtask

  // Called at posedge+1: drive inputs, settle, compare combinational outputs.
  task automatic drive(input logic [15:0] term, addr, datai, input logic rd, wr, we,
                       input logic [15:0] wd);
    di_term_addr = term; di_reg_addr = addr; di_reg_datai = datai;
    di_read = rd; di_write = wr; wr_en = we; wr_data = wd;
    #2;
    model_check();
  endtask

  // Clock edge: update the model from the applied inputs, then check the flags.
  task automatic advance();
    bit sel, wreg, flush;
    int sz;
    sel   = (di_term_addr == TermAddr);
    sz    = q.size();
    wreg  = sel && !di_reg_addr[15] && di_write;
    flush = wreg && di_reg_addr == 16'd0 && di_reg_datai[1];
    @(posedge ifclk);
    if (flush) begin
      q.delete();
    end else begin
      if (sel && di_reg_addr[15] && di_read) begin
        if (sz > 0) void'(q.pop_front());
        else if (m_unf < 65535) m_unf++;
      end
      if (wr_en && m_en) begin
        if (sz < Depth) q.push_back(wr_data);
        else if (m_ovf < 65535) m_ovf++;
      end
    end
    if (wreg) begin
      case (di_reg_addr)
        16'd0:   m_en = di_reg_datai[0];
        16'd2:   m_ovf = 0;
        16'd3:   m_unf = 0;
        default: ;
      endcase
    end
    #1;
    chk("model_fifo_full", fifo_full, q.size() == Depth);
    chk("model_fifo_empty", fifo_empty, q.size() == 0);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
    drive(TermAddr, addr, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk(name, di_reg_datao, exp);
    advance();
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] data);
    drive(TermAddr, addr, data, 1'b0, 1'b1, 1'b0, 16'd0);
    advance();
  endtask

  task automatic push_word(input logic [15:0] d);
    drive(TermAddr, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1, d);
    advance();
  endtask

  vec_t tbl[18];
  logic [15:0] seq_in, seq_out;

  initial begin
    tbl[0]  = v(TermAddr,     16'h0000, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[1]  = v(TermAddr,     16'h0001, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[2]  = v(TermAddr,     16'h0002, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[3]  = v(TermAddr,     16'h0003, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[4]  = v(TermAddr,     16'h0004, 16'h0, 0, 0, 0, 16'h0,  16'd512, 1, 1);
    tbl[5]  = v(TermAddr,     16'h0007, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[6]  = v(TermAddr + 1, 16'h0004, 16'h0, 1, 1, 0, 16'h0,  16'h0,   0, 0);
    tbl[7]  = v(TermAddr,     16'h8000, 16'h0, 0, 0, 0, 16'h0,  16'h0,   0, 1);
    tbl[8]  = v(TermAddr,     16'h8000, 16'h0, 1, 0, 0, 16'h0,  16'h0,   0, 1);
    tbl[9]  = v(TermAddr,     16'h0003, 16'h0, 0, 0, 0, 16'h0,  16'h1,   1, 1);
    tbl[10] = v(TermAddr,     16'h0003, 16'h0, 0, 1, 0, 16'h0,  16'h1,   1, 1);
    tbl[11] = v(TermAddr,     16'h0003, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);
    tbl[12] = v(TermAddr,     16'h0000, 16'h1, 0, 1, 0, 16'h0,  16'h0,   1, 1);
    tbl[13] = v(TermAddr,     16'h0000, 16'h0, 0, 0, 0, 16'h0,  16'h1,   1, 1);
    tbl[14] = v(TermAddr,     16'h8000, 16'h0, 0, 0, 1, 16'h55, 16'h0,   0, 1);
    tbl[15] = v(TermAddr,     16'h8001, 16'h0, 0, 0, 0, 16'h0,  16'h55,  1, 1);
    tbl[16] = v(TermAddr,     16'h8002, 16'h0, 1, 0, 0, 16'h0,  16'h55,  0, 1);
    tbl[17] = v(TermAddr,     16'h0001, 16'h0, 0, 0, 0, 16'h0,  16'h0,   1, 1);

    // Reset
    repeat (2) @(posedge ifclk);
    #1;
    chk("reset_fifo_empty", fifo_empty, 1'b1);
    chk("reset_fifo_full", fifo_full, 1'b0);
    resetb = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].term, tbl[i].addr, tbl[i].datai, tbl[i].rd, tbl[i].wr, tbl[i].we, tbl[i].wd);
      chk($sformatf("vec%0d_datao", i), di_reg_datao, tbl[i].e_do);
      chk($sformatf("vec%0d_read_rdy", i), di_read_rdy, tbl[i].e_rr);
      chk($sformatf("vec%0d_write_rdy", i), di_write_rdy, tbl[i].e_wr);
      advance();
    end

    // Five-word burst
    wr_reg(16'd0, 16'd1);
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    for (int i = 0; i < 5; i++) begin
      drive(TermAddr, 16'h8000 + 16'(i), 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      chk("burst_data", di_reg_datao, 32'(i + 1));
      chk("burst_read_rdy", di_read_rdy, i < 4);
      advance();
    end
    rd_chk("burst_count", 16'd1, 16'd0);
    rd_chk("burst_underflow", 16'd3, 16'd0);

    // Overfill: 600 pushes into 512 words
    for (int i = 0; i < 600; i++) push_word(16'(i));
    chk("fill_fifo_full", fifo_full, 1'b1);
    rd_chk("fill_count", 16'd1, 16'd512);
    rd_chk("fill_overflow", 16'd2, 16'd88);
    for (int i = 0; i < 512; i++) begin
      drive(TermAddr, 16'h8000 + 16'(i), 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      chk("fill_data", di_reg_datao, 32'(i));
      advance();
    end
    wr_reg(16'd2, 16'd0);
    rd_chk("overflow_cleared", 16'd2, 16'd0);
    drive(TermAddr, 16'h8000, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    advance();
    rd_chk("underflow_one", 16'd3, 16'd1);
    wr_reg(16'd3, 16'hFFFF);

    // Concurrent streaming at fill level 3
    seq_in = 16'h1000; seq_out = 16'h1000;
    for (int i = 0; i < 3; i++) begin push_word(seq_in); seq_in++; end
    for (int i = 0; i < 1000; i++) begin
      drive(TermAddr, 16'h8000 | 16'(i), 16'd0, 1'b1, 1'b0, 1'b1, seq_in);
      chk("stream_data", di_reg_datao, seq_out);
      seq_in++; seq_out++;
      advance();
    end
    rd_chk("stream_count", 16'd1, 16'd3);

    // Flush with a concurrent push
    for (int i = 0; i < 10; i++) push_word(16'hA000 + 16'(i));
    drive(TermAddr, 16'd0, 16'h0003, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    advance();
    chk("flush_fifo_empty", fifo_empty, 1'b1);
    rd_chk("flush_count", 16'd1, 16'd0);
    rd_chk("flush_enable", 16'd0, 16'd1);
    rd_chk("flush_overflow", 16'd2, 16'd0);
    push_word(16'h7777);
    rd_chk("post_flush_count", 16'd1, 16'd1);

    // Unselected terminal
    drive(TermAddr + 16'd1, 16'h8000, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("unsel_datao", di_reg_datao, 16'd0);
    chk("unsel_read_rdy", di_read_rdy, 1'b0);
    chk("unsel_write_rdy", di_write_rdy, 1'b0);
    advance();
    drive(TermAddr + 16'd1, 16'd0, 16'h0002, 1'b0, 1'b1, 1'b0, 16'd0);
    advance();
    rd_chk("unsel_count", 16'd1, 16'd1);
    rd_chk("unsel_ctrl", 16'd0, 16'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] term, addr, datai;
      logic rd, wr, we;
      int r;
      term = ($urandom % 8 == 0) ? TermAddr + 16'd1 : TermAddr;
      r = int'($urandom % 8);
      addr = (r < 5) ? 16'(r) : (r == 5) ? 16'd7 : (16'h8000 | 16'($urandom));
      rd = ($urandom % 100) < ((i < 1500) ? 20 : 70);
      wr = ($urandom % 12 == 0);
      datai = (16'($urandom) & 16'hFFFC) | {14'd0, ($urandom % 40 == 0), ($urandom % 8 != 0)};
      we = ($urandom % 100) < 75;
      drive(term, addr, datai, rd, wr, we, 16'($urandom));
      advance();
    end

    // Asynchronous reset mid-burst
    wr_reg(16'd0, 16'd1);
    for (int i = 0; i < 5; i++) push_word(16'h3000 + 16'(i));
    for (int i = 0; i < 2; i++) begin
      drive(TermAddr, 16'h8000, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      advance();
    end
    drive(TermAddr, 16'h8000, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    #1;
    resetb = 1'b0;
    #1;
    chk("async_rst_empty", fifo_empty, 1'b1);
    chk("async_rst_full", fifo_full, 1'b0);
    chk("async_rst_read_rdy", di_read_rdy, 1'b0);
    chk("async_rst_datao", di_reg_datao, 16'd0);
    q.delete(); m_en = 1'b0; m_ovf = 0; m_unf = 0;
    @(posedge ifclk);
    #1;
    resetb = 1'b1;
    rd_chk("async_rst_enable", 16'd0, 16'd0);
    rd_chk("async_rst_count", 16'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/di_stream_fifo_term.md
Name: di_stream_fifo_term

Overview:
- Device-interface (di_*) terminal directly downstream of the host interface block. It buffers a 16-bit data stream from a local producer in a synchronous FIFO and serves it to host read bursts.
- It also exposes a small control/status register set.
- Claims one terminal address. When not addressed, it drives zero, so several terminals can be OR-combined onto di_reg_datao / di_read_rdy / di_write_rdy.

Parameters:
- TERM_ADDR, 16'h0010, terminal address matched against di_term_addr.
- DEPTH_LOG2, 9, FIFO depth = 2^DEPTH_LOG2 words of 16 bits; legal range 2..15.

Ports:
- ifclk  input  1  clock; all logic on rising edge
- resetb  input  1  asynchronous, active-low reset
- di_term_addr  input  16  selected terminal
- di_reg_addr  input  16  register address; addr[15]=1 is data window, addr[15]=0 is register space
- di_reg_datai  input  16  host write data
- di_reg_datao  output  16  read data (combinational)
- di_read  input  1  host read strobe; one word consumed per high cycle
- di_read_rdy  output  1  read may be issued next cycle (combinational)
- di_write  input  1  host write strobe
- di_write_rdy  output  1  write accepted (combinational)
- wr_en  input  1  producer push strobe
- wr_data  input  16  producer data
- fifo_full  output  1  count == DEPTH (registered)
- fifo_empty  output  1  count == 0 (registered)

Behaviour:
- sel = (di_term_addr == TERM_ADDR). If sel=0: di_reg_datao=0, di_read_rdy=0, di_write_rdy=0, and di_read/di_write are ignored.
- Reset values: all FIFO pointers 0; count 0; enable 0; overflow 0; underflow 0; fifo_full 0; fifo_empty 1.
- Data window (sel and addr[15]=1):
  - di_reg_datao = FIFO head word, first-word-fall-through. The host captures it on the same edge where di_read=1; the FIFO pops on that edge.
  - di_read_rdy = (count > di_read). This lets the host's registered rdy stay correct when one word remains.
  - If di_read=1 while count=0: no pop, underflow increments (saturates at 16'hFFFF), di_reg_datao=0.
  - Host address auto-increment is tolerated. Any addr[15]=1 address is the data port. Bursts over 32768 words wrap into register space and are host error.
- Register space (sel and addr[15]=0). di_read_rdy=1 and di_write_rdy=1. Reads are side-effect free. Writes take effect on the edge with di_write=1.
  - 0 CTRL: rw. bit0 enable; bit1 flush (write 1, self-clears, reads 0).
  - 1 COUNT: ro. Fill count, 0..DEPTH.
  - 2 OVERFLOW: ro. Saturating dropped-word count; any write clears it to 0.
  - 3 UNDERFLOW: ro. Saturating empty-read count; any write clears it to 0.
  - 4 DEPTH: ro. 2^DEPTH_LOG2.
  - Other addresses read 0; writes to them are ignored.
- Writes in the data window: ignored, di_write_rdy=1.
- Producer push:
  - wr_en=1, enable=1, and count<DEPTH (count sampled before any same-cycle pop): word stored at wptr, wptr wraps modulo DEPTH.
  - wr_en=1, enable=1, full: word dropped, overflow increments (saturating).
  - wr_en=1, enable=0: word silently dropped; no counter change.
- Simultaneous push and pop (non-full, non-empty): count unchanged, both pointers advance.
- Flush (CTRL write with bit1=1):
  - Next edge: wptr=rptr=count=0.
  - A push or pop in the flush cycle is discarded and not counted.
  - Enable takes the bit0 value written in the same cycle.
- Counter saturation: overflow and underflow hold at 16'hFFFF; a clear write in the same cycle as an increment wins, giving 0.
- fifo_full/fifo_empty are updated on the same edge as count.
- Mid-operation reset: asynchronous. FIFO contents are lost and outputs return to reset values immediately; RAM contents need not be cleared.
- Storage is an inferred single-clock RAM with registered write and asynchronous read, or an equivalent head register, so that the head is valid in the cycle after the push that makes count=1.

Test Plan:
- Reset, then read regs 0..4 with TERM_ADDR selected -> 0, 0, 0, 0, 512 (defaults); fifo_empty=1.
- Write CTRL=1, push 16'h0001..16'h0005 on consecutive cycles, host 5-word burst at addr 16'h8000 -> data 1,2,3,4,5 in order; di_read_rdy drops after the 4th pop so no 6th read is issued; COUNT=0; UNDERFLOW=0.
- Enable, push 600 words with no reads (DEPTH 512) -> fifo_full=1, COUNT=512, OVERFLOW=88; burst read returns words 0..511; write reg 2 -> OVERFLOW=0.
- Concurrent push and read stream for 1000 cycles at fill level 3 -> COUNT stays 3, data sequence contiguous, no loss.
- Fill 10 words, write CTRL=16'h0003 in the same cycle as wr_en -> COUNT=0, fifo_empty=1, enable remains 1, OVERFLOW unchanged; next push makes COUNT=1.
- di_term_addr=TERM_ADDR+1 -> di_reg_datao=0, di_read_rdy=0, di_write_rdy=0; di_read/di_write pulses leave COUNT and CTRL unchanged; assert resetb low mid-burst -> COUNT=0, enable=0 asynchronously.
